// File: rtl/cpu_addr_stack_pkg.sv
// Shared definitions for the program-address stack: default geometry and the
// decoded command encoding, in priority order.
package cpu_addr_stack_pkg;

  localparam int AW_DEFAULT    = 14;
  localparam int DEPTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    CMD_IDLE,
    CMD_WRITE,
    CMD_CALL,
    CMD_PUSH,
    CMD_POP,
    CMD_POP_LOAD,
    CMD_LOAD,
    CMD_INCR
  } cmd_e;

  // Push and pop together cancel, letting load or increment through.
  function automatic cmd_e decode_cmd(input logic wr, input logic push,
                                      input logic pop, input logic load,
                                      input logic incr);
    cmd_e cmd;
    if (wr)                cmd = CMD_WRITE;
    else if (push && !pop) cmd = load ? CMD_CALL : CMD_PUSH;
    else if (pop && !push) cmd = load ? CMD_POP_LOAD : CMD_POP;
    else if (load)         cmd = CMD_LOAD;
    else if (incr)         cmd = CMD_INCR;
    else                   cmd = CMD_IDLE;
    return cmd;
  endfunction

endpackage

// File: rtl/cpu_addr_stack_if.sv
// Command/status bundle between the instruction decoder and the address stack.
interface cpu_addr_stack_if
  import cpu_addr_stack_pkg::*;
#(
  parameter int AW    = AW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
);
  localparam int PW = $clog2(DEPTH);

  logic          RD_I;
  logic          WR_I;
  logic          HA_I;
  logic          INCR_I;
  logic          PUSH_I;
  logic          POP_I;
  logic          LOAD_I;
  logic          CLR_I;
  logic [AW-1:0] ADR_I;
  logic [7:0]    DAT_I;
  logic [7:0]    DAT_O;
  logic [AW-1:0] PC_O;
  logic [PW-1:0] LVL_O;
  logic          OVF_O;
  logic          UDF_O;

  modport master (
    output RD_I, WR_I, HA_I, INCR_I, PUSH_I, POP_I, LOAD_I, CLR_I, ADR_I, DAT_I,
    input  DAT_O, PC_O, LVL_O, OVF_O, UDF_O
  );

  modport slave (
    input  RD_I, WR_I, HA_I, INCR_I, PUSH_I, POP_I, LOAD_I, CLR_I, ADR_I, DAT_I,
    output DAT_O, PC_O, LVL_O, OVF_O, UDF_O
  );

endinterface

// File: rtl/cpu_addr_stack_ptr.sv
// Stack pointer, saturating level counter and sticky overflow/underflow flags,
// driven by already-decoded push/pop requests.
module cpu_addr_stack_ptr
  import cpu_addr_stack_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clr_i,
  output logic [PW-1:0] ptr_o,
  output logic [PW-1:0] ptr_up_o,
  output logic [PW-1:0] ptr_dn_o,
  output logic [PW-1:0] lvl_o,
  output logic          ovf_o,
  output logic          udf_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] lvl_q, lvl_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  assign ptr_up_o = ptr_q + PW'(1);
  assign ptr_dn_o = ptr_q - PW'(1);

  // The pointer always wraps; the level saturates and the flag records it.
  always_comb begin
    ptr_d = ptr_q;
    lvl_d = lvl_q;
    ovf_d = ovf_q & ~clr_i;
    udf_d = udf_q & ~clr_i;
    if (push_i) begin
      ptr_d = ptr_up_o;
      if (lvl_q == PW'(DEPTH - 1)) ovf_d = 1'b1;
      else                         lvl_d = lvl_q + PW'(1);
    end else if (pop_i) begin
      ptr_d = ptr_dn_o;
      if (lvl_q == '0) udf_d = 1'b1;
      else             lvl_d = lvl_q - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ptr_o = ptr_q;
  assign lvl_o = lvl_q;
  assign ovf_o = ovf_q;
  assign udf_o = udf_q;

endmodule

// File: rtl/cpu_addr_stack.sv
// Program-address stack: entry array, byte read/write muxing and command
// decode; the entry at the pointer is the live program counter.
module cpu_addr_stack
  import cpu_addr_stack_pkg::*;
#(
  parameter int AW    = AW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             CLK_I,
  input  logic             nRST_I,
  cpu_addr_stack_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);

  cmd_e          cmd;
  logic          push_en;
  logic          pop_en;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_up;
  logic [PW-1:0] ptr_dn;
  logic [PW-1:0] lvl;
  logic          ovf;
  logic          udf;
  logic [AW-1:0] mem_q [DEPTH];
  logic [AW-1:0] mem_d [DEPTH];
  logic [AW-1:0] cur_pc;
  logic [7:0]    hi_byte;

  always_comb begin
    cmd     = decode_cmd(bus.WR_I, bus.PUSH_I, bus.POP_I, bus.LOAD_I, bus.INCR_I);
    push_en = (cmd == CMD_CALL) || (cmd == CMD_PUSH);
    pop_en  = (cmd == CMD_POP)  || (cmd == CMD_POP_LOAD);
  end

  cpu_addr_stack_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk      (CLK_I),
    .rst_n    (nRST_I),
    .push_i   (push_en),
    .pop_i    (pop_en),
    .clr_i    (bus.CLR_I),
    .ptr_o    (ptr),
    .ptr_up_o (ptr_up),
    .ptr_dn_o (ptr_dn),
    .lvl_o    (lvl),
    .ovf_o    (ovf),
    .udf_o    (udf)
  );

  // Call and pop-load write the entry the pointer is about to move to.
  always_comb begin
    mem_d = mem_q;
    unique case (cmd)
      CMD_WRITE: begin
        if (bus.HA_I) mem_d[ptr][AW-1:8] = bus.DAT_I[AW-9:0];
        else          mem_d[ptr][7:0]    = bus.DAT_I;
      end
      CMD_CALL:     mem_d[ptr_up] = bus.ADR_I;
      CMD_POP_LOAD: mem_d[ptr_dn] = bus.ADR_I;
      CMD_LOAD:     mem_d[ptr]    = bus.ADR_I;
      CMD_INCR:     mem_d[ptr]    = mem_q[ptr] + AW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge CLK_I or negedge nRST_I) begin
    if (!nRST_I) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    cur_pc               = mem_q[ptr];
    hi_byte              = '0;
    hi_byte[AW-9:0]      = cur_pc[AW-1:8];
  end

  assign bus.DAT_O = !bus.RD_I ? 8'h00 : (bus.HA_I ? hi_byte : cur_pc[7:0]);
  assign bus.PC_O  = cur_pc;
  assign bus.LVL_O = lvl;
  assign bus.OVF_O = ovf;
  assign bus.UDF_O = udf;

endmodule

// File: tb/tb_cpu_addr_stack.sv
// Self-checking bench for cpu_addr_stack: directed scenarios followed by
// randomized commands compared against an array-based reference model.
module tb_cpu_addr_stack;

  localparam int AW    = 14;
  localparam int DEPTH = 8;
  localparam int PW    = $clog2(DEPTH);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cpu_addr_stack_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

  cpu_addr_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
    .CLK_I  (clk),
    .nRST_I (rst_n),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: plain integer stack with explicit level and flags.
  int m_mem [DEPTH];
  int m_ptr;
  int m_lvl;
  bit m_ovf;
  bit m_udf;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    m_ptr = 0;
    m_lvl = 0;
    m_ovf = 0;
    m_udf = 0;
  endfunction

  function automatic void model_step();
    bit set_o = 0;
    bit set_u = 0;
    int amask = (1 << AW) - 1;
    if (bus.WR_I) begin
      if (bus.HA_I)
        m_mem[m_ptr] = (m_mem[m_ptr] & 'hFF) |
                       ((int'(bus.DAT_I) & ((1 << (AW - 8)) - 1)) << 8);
      else
        m_mem[m_ptr] = (m_mem[m_ptr] & (amask ^ 'hFF)) | int'(bus.DAT_I);
    end else if (bus.PUSH_I && !bus.POP_I) begin
      if (m_lvl == DEPTH - 1) set_o = 1; else m_lvl++;
      m_ptr = (m_ptr + 1) % DEPTH;
      if (bus.LOAD_I) m_mem[m_ptr] = int'(bus.ADR_I);
    end else if (bus.POP_I && !bus.PUSH_I) begin
      if (m_lvl == 0) set_u = 1; else m_lvl--;
      m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
      if (bus.LOAD_I) m_mem[m_ptr] = int'(bus.ADR_I);
    end else if (bus.LOAD_I) begin
      m_mem[m_ptr] = int'(bus.ADR_I);
    end else if (bus.INCR_I) begin
      m_mem[m_ptr] = (m_mem[m_ptr] + 1) % (1 << AW);
    end
    m_ovf = set_o | (m_ovf & !bus.CLR_I);
    m_udf = set_u | (m_udf & !bus.CLR_I);
  endfunction

  function automatic logic [7:0] exp_dat();
    int pc = m_mem[m_ptr];
    if (!bus.RD_I) return 8'h00;
    return bus.HA_I ? 8'(pc >> 8) : 8'(pc & 'hFF);
  endfunction

  task automatic idle_inputs();
    bus.RD_I   = 1'b0;
    bus.WR_I   = 1'b0;
    bus.HA_I   = 1'b0;
    bus.INCR_I = 1'b0;
    bus.PUSH_I = 1'b0;
    bus.POP_I  = 1'b0;
    bus.LOAD_I = 1'b0;
    bus.CLR_I  = 1'b0;
    bus.ADR_I  = '0;
    bus.DAT_I  = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    bus.RD_I = 1'b1;
    bus.HA_I = 1'b0;
    #1;
    checks++;
    if (bus.DAT_O !== 8'h00) begin errors++; $display("[TB] FAIL reset_dat_lo: got %h want 00", bus.DAT_O); end
    bus.HA_I = 1'b1;
    #1;
    checks++;
    if (bus.DAT_O !== 8'h00) begin errors++; $display("[TB] FAIL reset_dat_hi: got %h want 00", bus.DAT_O); end
    checks++;
    if (bus.PC_O !== 14'h0000) begin errors++; $display("[TB] FAIL reset_pc: got %h want 0000", bus.PC_O); end
    checks++;
    if (bus.LVL_O !== 3'd0) begin errors++; $display("[TB] FAIL reset_lvl: got %0d want 0", bus.LVL_O); end
    checks++;
    if (bus.OVF_O !== 1'b0 || bus.UDF_O !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got ovf=%b udf=%b want 0 0", bus.OVF_O, bus.UDF_O);
    end
    idle_inputs();
  endtask

  task automatic test_byte_write_incr();
    bus.RD_I  = 1'b1;
    bus.HA_I  = 1'b1;
    bus.WR_I  = 1'b1;
    bus.DAT_I = 8'hFF;
    #1;
    checks++;
    if (bus.DAT_O !== 8'h00) begin errors++; $display("[TB] FAIL read_during_write: got %h want 00", bus.DAT_O); end
    tick();
    checks++;
    if (bus.DAT_O !== 8'h3F) begin errors++; $display("[TB] FAIL high_write_read: got %h want 3f", bus.DAT_O); end
    bus.HA_I = 1'b0;
    tick();
    bus.WR_I = 1'b0;
    checks++;
    if (bus.PC_O !== 14'h3FFF) begin errors++; $display("[TB] FAIL pc_after_writes: got %h want 3fff", bus.PC_O); end
    checks++;
    if (bus.DAT_O !== 8'hFF) begin errors++; $display("[TB] FAIL low_read: got %h want ff", bus.DAT_O); end
    bus.RD_I   = 1'b0;
    bus.INCR_I = 1'b1;
    tick();
    bus.INCR_I = 1'b0;
    checks++;
    if (bus.PC_O !== 14'h0000) begin errors++; $display("[TB] FAIL incr_wrap: got %h want 0000", bus.PC_O); end
    checks++;
    if (bus.DAT_O !== 8'h00) begin errors++; $display("[TB] FAIL dat_idle: got %h want 00", bus.DAT_O); end
  endtask

  task automatic test_call_return();
    bus.LOAD_I = 1'b1;
    bus.ADR_I  = 14'h0123;
    tick();
    bus.LOAD_I = 1'b0;
    checks++;
    if (bus.PC_O !== 14'h0123) begin errors++; $display("[TB] FAIL load_pc: got %h want 0123", bus.PC_O); end
    bus.INCR_I = 1'b1;
    tick();
    bus.INCR_I = 1'b0;
    bus.PUSH_I = 1'b1;
    bus.LOAD_I = 1'b1;
    bus.ADR_I  = 14'h2000;
    tick();
    bus.PUSH_I = 1'b0;
    bus.LOAD_I = 1'b0;
    checks++;
    if (bus.PC_O !== 14'h2000) begin errors++; $display("[TB] FAIL call_pc: got %h want 2000", bus.PC_O); end
    checks++;
    if (bus.LVL_O !== 3'd1) begin errors++; $display("[TB] FAIL call_lvl: got %0d want 1", bus.LVL_O); end
    bus.POP_I = 1'b1;
    tick();
    bus.POP_I = 1'b0;
    checks++;
    if (bus.PC_O !== 14'h0124) begin errors++; $display("[TB] FAIL ret_pc: got %h want 0124", bus.PC_O); end
    checks++;
    if (bus.LVL_O !== 3'd0 || bus.UDF_O !== 1'b0) begin
      errors++; $display("[TB] FAIL ret_lvl: got lvl=%0d udf=%b want 0 0", bus.LVL_O, bus.UDF_O);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.LOAD_I = 1'b1;
    bus.ADR_I  = 14'h0ABC;
    tick();
    bus.LOAD_I = 1'b0;
    bus.PUSH_I = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      if (i == DEPTH - 1) begin
        checks++;
        if (bus.LVL_O !== 3'd7 || bus.OVF_O !== 1'b0) begin
          errors++; $display("[TB] FAIL pre_overflow: got lvl=%0d ovf=%b want 7 0", bus.LVL_O, bus.OVF_O);
        end
      end
    end
    bus.PUSH_I = 1'b0;
    checks++;
    if (bus.LVL_O !== 3'd7 || bus.OVF_O !== 1'b1) begin
      errors++; $display("[TB] FAIL overflow: got lvl=%0d ovf=%b want 7 1", bus.LVL_O, bus.OVF_O);
    end
    checks++;
    if (bus.PC_O !== 14'h0ABC) begin errors++; $display("[TB] FAIL overflow_wrap_pc: got %h want 0abc", bus.PC_O); end
  endtask

  task automatic test_underflow_flags();
    bus.POP_I = 1'b1;
    repeat (DEPTH - 1) tick();
    checks++;
    if (bus.LVL_O !== 3'd0 || bus.UDF_O !== 1'b0) begin
      errors++; $display("[TB] FAIL pops_to_empty: got lvl=%0d udf=%b want 0 0", bus.LVL_O, bus.UDF_O);
    end
    tick();
    bus.POP_I = 1'b0;
    checks++;
    if (bus.UDF_O !== 1'b1 || bus.LVL_O !== 3'd0 || bus.OVF_O !== 1'b1) begin
      errors++; $display("[TB] FAIL underflow: got udf=%b lvl=%0d ovf=%b want 1 0 1", bus.UDF_O, bus.LVL_O, bus.OVF_O);
    end
    checks++;
    if (bus.PC_O !== 14'h0ABC) begin errors++; $display("[TB] FAIL underflow_wrap_pc: got %h want 0abc", bus.PC_O); end
    bus.CLR_I = 1'b1;
    tick();
    bus.CLR_I = 1'b0;
    checks++;
    if (bus.OVF_O !== 1'b0 || bus.UDF_O !== 1'b0) begin
      errors++; $display("[TB] FAIL clr_flags: got ovf=%b udf=%b want 0 0", bus.OVF_O, bus.UDF_O);
    end
    bus.CLR_I = 1'b1;
    bus.POP_I = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (bus.UDF_O !== 1'b1 || bus.LVL_O !== 3'd0) begin
      errors++; $display("[TB] FAIL clr_vs_set: got udf=%b lvl=%0d want 1 0", bus.UDF_O, bus.LVL_O);
    end
  endtask

  task automatic test_simultaneous();
    logic [AW-1:0] pc_before;
    logic [PW-1:0] lvl_before;
    pc_before  = AW'(m_mem[m_ptr]);
    lvl_before = PW'(m_lvl);
    bus.WR_I   = 1'b1;
    bus.PUSH_I = 1'b1;
    bus.HA_I   = 1'b0;
    bus.DAT_I  = 8'h5A;
    tick();
    idle_inputs();
    checks++;
    if (bus.PC_O !== {pc_before[AW-1:8], 8'h5A}) begin
      errors++; $display("[TB] FAIL wr_push_pc: got %h want %h", bus.PC_O, {pc_before[AW-1:8], 8'h5A});
    end
    checks++;
    if (bus.LVL_O !== lvl_before) begin errors++; $display("[TB] FAIL wr_push_lvl: got %0d want %0d", bus.LVL_O, lvl_before); end
    pc_before  = AW'(m_mem[m_ptr]);
    bus.PUSH_I = 1'b1;
    bus.POP_I  = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (bus.PC_O !== pc_before || bus.LVL_O !== lvl_before || bus.UDF_O !== m_udf || bus.OVF_O !== m_ovf) begin
      errors++; $display("[TB] FAIL push_pop_nop: got pc=%h lvl=%0d want pc=%h lvl=%0d",
                         bus.PC_O, bus.LVL_O, pc_before, lvl_before);
    end
  endtask

  task automatic test_async_reset();
    bus.PUSH_I = 1'b1;
    bus.LOAD_I = 1'b1;
    bus.ADR_I  = 14'h1555;
    tick();
    idle_inputs();
    bus.RD_I = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.PC_O !== 14'h0000 || bus.LVL_O !== 3'd0) begin
      errors++; $display("[TB] FAIL async_reset_pc_lvl: got pc=%h lvl=%0d want 0000 0", bus.PC_O, bus.LVL_O);
    end
    checks++;
    if (bus.OVF_O !== 1'b0 || bus.UDF_O !== 1'b0 || bus.DAT_O !== 8'h00) begin
      errors++; $display("[TB] FAIL async_reset_flags_dat: got ovf=%b udf=%b dat=%h want 0 0 00",
                         bus.OVF_O, bus.UDF_O, bus.DAT_O);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.WR_I   = ($urandom_range(0, 7) == 0);
      bus.PUSH_I = ($urandom_range(0, 3) == 0);
      bus.POP_I  = ($urandom_range(0, 3) == 0);
      bus.LOAD_I = ($urandom_range(0, 3) == 0);
      bus.INCR_I = ($urandom_range(0, 2) == 0);
      bus.CLR_I  = ($urandom_range(0, 7) == 0);
      bus.RD_I   = ($urandom_range(0, 1) == 0);
      bus.HA_I   = ($urandom_range(0, 1) == 0);
      bus.ADR_I  = AW'($urandom);
      bus.DAT_I  = 8'($urandom);
      tick();
      checks++;
      if (bus.PC_O !== AW'(m_mem[m_ptr])) begin
        errors++; $display("[TB] FAIL rand_pc[%0d]: got %h want %h", n, bus.PC_O, AW'(m_mem[m_ptr]));
      end
      checks++;
      if (bus.LVL_O !== PW'(m_lvl) || bus.OVF_O !== m_ovf || bus.UDF_O !== m_udf) begin
        errors++; $display("[TB] FAIL rand_status[%0d]: got lvl=%0d ovf=%b udf=%b want %0d %b %b",
                           n, bus.LVL_O, bus.OVF_O, bus.UDF_O, m_lvl, m_ovf, m_udf);
      end
      checks++;
      if (bus.DAT_O !== exp_dat()) begin
        errors++; $display("[TB] FAIL rand_dat[%0d]: got %h want %h", n, bus.DAT_O, exp_dat());
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_byte_write_incr();
    test_call_return();
    test_overflow();
    test_underflow_flags();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
